// File: rtl/regfile_cmd_ctrl_pkg.sv
// Shared opcodes and FSM state encoding for the register-file command sequencer.
package regfile_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_WR  = 8'hAA;
    localparam logic [7:0] CMD_RD  = 8'hBB;
    localparam logic [7:0] CMD_BRD = 8'hCC;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        BR_ADDR,
        BR_CNT,
        RD_REQ,
        RD_WAIT,
        TX_SEND
    } state_t;

endpackage

// File: rtl/regfile_cmd_txbuf.sv
// One-entry TX holding register: captures read data and pushes it to the FIFO
// as a single-cycle strobe once FIFO_FULL is low.
module regfile_cmd_txbuf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             full,
    output logic [WIDTH-1:0] data,
    output logic             vld
);

    logic pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            vld  <= 1'b0;
            pend <= 1'b0;
        end else if (load) begin
            data <= load_data;
            vld  <= !full;
            pend <= full;
        end else if (pend && !full) begin
            vld  <= 1'b1;
            pend <= 1'b0;
        end else begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_cmd_ctrl.sv
// Command sequencer: parses framed RX bytes into register-file write/read strobes
// and forwards read data (single or burst) to the TX FIFO.
module regfile_cmd_ctrl
    import regfile_cmd_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    input  logic             FIFO_FULL,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             CTRL_BUSY
);

    state_t           state;
    logic [ADDR-1:0]  addr_reg;
    logic [WIDTH-1:0] cnt;
    logic             tx_load;

    assign tx_load = (state == RD_WAIT) && RdData_VLD;

    function automatic logic [ADDR-1:0] next_addr(input logic [ADDR-1:0] a);
        return (a == ADDR'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    regfile_cmd_txbuf #(.WIDTH(WIDTH)) u_txbuf (
        .clk       (CLK),
        .rst_n     (RST),
        .load      (tx_load),
        .load_data (RdData),
        .full      (FIFO_FULL),
        .data      (TX_P_DATA),
        .vld       (TX_D_VLD)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            addr_reg  <= '0;
            cnt       <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            CTRL_BUSY <= 1'b0;
        end else begin
            WrEn <= 1'b0;
            RdEn <= 1'b0;
            case (state)
                IDLE: if (RX_D_VLD) begin
                    if (RX_P_DATA == WIDTH'(CMD_WR))       state <= WR_ADDR;
                    else if (RX_P_DATA == WIDTH'(CMD_RD))  state <= RD_ADDR;
                    else if (RX_P_DATA == WIDTH'(CMD_BRD)) state <= BR_ADDR;
                end
                WR_ADDR: if (RX_D_VLD) begin
                    addr_reg <= RX_P_DATA[ADDR-1:0];
                    state    <= WR_DATA;
                end
                WR_DATA: if (RX_D_VLD) begin
                    Address <= addr_reg;
                    WrData  <= RX_P_DATA;
                    WrEn    <= 1'b1;
                    state   <= IDLE;
                end
                // A single read is a burst of one, so TX_SEND has one exit rule.
                RD_ADDR: if (RX_D_VLD) begin
                    Address   <= RX_P_DATA[ADDR-1:0];
                    RdEn      <= 1'b1;
                    cnt       <= WIDTH'(1);
                    CTRL_BUSY <= 1'b1;
                    state     <= RD_REQ;
                end
                BR_ADDR: if (RX_D_VLD) begin
                    addr_reg <= RX_P_DATA[ADDR-1:0];
                    state    <= BR_CNT;
                end
                BR_CNT: if (RX_D_VLD) begin
                    if (RX_P_DATA == '0) begin
                        state <= IDLE;
                    end else begin
                        Address   <= addr_reg;
                        RdEn      <= 1'b1;
                        cnt       <= RX_P_DATA;
                        CTRL_BUSY <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: if (RdData_VLD) state <= TX_SEND;
                // TX_D_VLD high means the push is happening this cycle.
                TX_SEND: if (TX_D_VLD) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == WIDTH'(1)) begin
                        CTRL_BUSY <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        Address <= next_addr(Address);
                        RdEn    <= 1'b1;
                        state   <= RD_REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Scoreboard bench for regfile_cmd_ctrl with a small register-file model.
module tb_regfile_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] RdData;
    logic       RdData_VLD;
    logic       FIFO_FULL = 1'b0;
    logic       WrEn, RdEn, TX_D_VLD, CTRL_BUSY;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0;
    int last_rd_cyc = 0, last_tx_cyc = 0;

    logic [7:0]  exp_tx[$];
    logic [3:0]  exp_rd[$];
    logic [11:0] exp_wr[$];
    logic [7:0]  exp_mem [16];

    always #5 CLK = ~CLK;

    regfile_cmd_ctrl #(.WIDTH(8), .ADDR(4), .DEPTH(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RdData     (RdData),
        .RdData_VLD (RdData_VLD),
        .FIFO_FULL  (FIFO_FULL),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .Address    (Address),
        .WrData     (WrData),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .CTRL_BUSY  (CTRL_BUSY)
    );

    // Register file model: reset contents 0x7F+i, read data one cycle after RdEn.
    initial begin
        logic [7:0] mem [16];
        for (int i = 0; i < 16; i++) mem[i] = 8'h7F + 8'(i);
        RdData     <= '0;
        RdData_VLD <= 1'b0;
        forever begin
            @(posedge CLK);
            if (WrEn) mem[Address] <= WrData;
            RdData_VLD <= RdEn;
            if (RdEn) RdData <= mem[Address];
        end
    end

    initial forever begin
        @(posedge CLK);
        cyc <= cyc + 1;
    end

    // Output monitor: every strobe pops and compares one scoreboard entry.
    initial forever begin
        logic [11:0] ew;
        logic [3:0]  er;
        logic [7:0]  et;
        @(negedge CLK);
        if (RST) begin
            checks++;
            if (WrEn && RdEn) begin
                errors++;
                $display("FAIL wr_rd_overlap: WrEn=%b RdEn=%b, required not both high", WrEn, RdEn);
            end
            if (WrEn) begin
                wr_cnt++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write", Address, WrData);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({Address, WrData} !== ew) begin
                        errors++;
                        $display("FAIL write: got addr/data %h, expected %h", {Address, WrData}, ew);
                    end
                end
            end
            if (RdEn) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: addr=%h, required no read", Address);
                end else begin
                    er = exp_rd.pop_front();
                    if (Address !== er) begin
                        errors++;
                        $display("FAIL read_addr: got %h, expected %h", Address, er);
                    end
                end
            end
            if (TX_D_VLD) begin
                tx_cnt++;
                last_tx_cyc = cyc;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx: data=%h, required no TX push", TX_P_DATA);
                end else begin
                    et = exp_tx.pop_front();
                    if (TX_P_DATA !== et) begin
                        errors++;
                        $display("FAIL tx_data: got %h, expected %h", TX_P_DATA, et);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1 RX_D_VLD = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_quiet(input int budget);
        int t = 0;
        while ((CTRL_BUSY || exp_tx.size() != 0 || exp_rd.size() != 0 || exp_wr.size() != 0)
               && t < budget) begin
            @(posedge CLK);
            #1;
            t++;
        end
        checks++;
        if (t >= budget) begin
            errors++;
            $display("FAIL timeout: busy=%b still pending after %0d cycles, required drain", CTRL_BUSY, t);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset();
        idle_cycles(3);
        checks += 7;
        if (WrEn !== 1'b0)      begin errors++; $display("FAIL reset_WrEn: got %b, expected 0", WrEn); end
        if (RdEn !== 1'b0)      begin errors++; $display("FAIL reset_RdEn: got %b, expected 0", RdEn); end
        if (Address !== 4'h0)   begin errors++; $display("FAIL reset_Address: got %h, expected 0", Address); end
        if (WrData !== 8'h00)   begin errors++; $display("FAIL reset_WrData: got %h, expected 0", WrData); end
        if (TX_P_DATA !== 8'h00) begin errors++; $display("FAIL reset_TX_P_DATA: got %h, expected 0", TX_P_DATA); end
        if (TX_D_VLD !== 1'b0)  begin errors++; $display("FAIL reset_TX_D_VLD: got %b, expected 0", TX_D_VLD); end
        if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL reset_CTRL_BUSY: got %b, expected 0", CTRL_BUSY); end
        RST = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_write();
        int w0 = wr_cnt, r0 = rd_cnt;
        exp_wr.push_back({4'h5, 8'h3C});
        exp_mem[5] = 8'h3C;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        checks++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h5, 8'h3C}) begin
            errors++;
            $display("FAIL write_strobe: got en/addr/data %b/%h/%h, expected 1/5/3c", WrEn, Address, WrData);
        end
        idle_cycles(1);
        checks++;
        if (WrEn !== 1'b0) begin errors++; $display("FAIL write_pulse_len: WrEn=%b one cycle later, expected 0", WrEn); end
        wait_quiet(10);
        checks += 2;
        if (wr_cnt - w0 != 1) begin errors++; $display("FAIL write_count: got %0d, expected 1", wr_cnt - w0); end
        if (rd_cnt != r0)     begin errors++; $display("FAIL write_no_read: got %0d reads, expected 0", rd_cnt - r0); end
    endtask

    task automatic test_read();
        int t0 = tx_cnt;
        exp_rd.push_back(4'h5);
        exp_tx.push_back(exp_mem[5]);
        send_byte(8'hBB); send_byte(8'h05);
        checks++;
        if ({CTRL_BUSY, RdEn} !== 2'b11) begin
            errors++;
            $display("FAIL read_issue: got busy/RdEn %b/%b, expected 1/1", CTRL_BUSY, RdEn);
        end
        wait_quiet(20);
        checks += 2;
        if (tx_cnt - t0 != 1) begin errors++; $display("FAIL read_tx_count: got %0d, expected 1", tx_cnt - t0); end
        if (last_tx_cyc - last_rd_cyc != 2) begin
            errors++;
            $display("FAIL read_latency: got %0d cycles RdEn->TX, expected 2", last_tx_cyc - last_rd_cyc);
        end
    endtask

    task automatic test_fifo_full();
        int t0 = tx_cnt;
        int drop;
        FIFO_FULL = 1'b1;
        exp_rd.push_back(4'h2);
        exp_tx.push_back(exp_mem[2]);
        send_byte(8'hBB); send_byte(8'h02);
        idle_cycles(10);
        checks += 2;
        if (tx_cnt != t0)       begin errors++; $display("FAIL full_hold: got %0d pushes while full, expected 0", tx_cnt - t0); end
        if (CTRL_BUSY !== 1'b1) begin errors++; $display("FAIL full_busy: got %b, expected 1", CTRL_BUSY); end
        drop = cyc;
        FIFO_FULL = 1'b0;
        wait_quiet(20);
        checks += 2;
        if (tx_cnt - t0 != 1) begin errors++; $display("FAIL full_tx_count: got %0d, expected 1", tx_cnt - t0); end
        if (last_tx_cyc != drop + 1) begin
            errors++;
            $display("FAIL full_release: push at cycle %0d, expected %0d", last_tx_cyc, drop + 1);
        end
    endtask

    task automatic test_burst();
        int t0 = tx_cnt, r0 = rd_cnt;
        exp_rd.push_back(4'hE); exp_tx.push_back(exp_mem[14]);
        exp_rd.push_back(4'hF); exp_tx.push_back(exp_mem[15]);
        exp_rd.push_back(4'h0); exp_tx.push_back(exp_mem[0]);
        send_byte(8'hCC); send_byte(8'h0E); send_byte(8'h03);
        wait_quiet(60);
        checks += 2;
        if (tx_cnt - t0 != 3) begin errors++; $display("FAIL burst_tx_count: got %0d, expected 3", tx_cnt - t0); end
        if (rd_cnt - r0 != 3) begin errors++; $display("FAIL burst_rd_count: got %0d, expected 3", rd_cnt - r0); end
        r0 = rd_cnt;
        send_byte(8'hCC); send_byte(8'h00); send_byte(8'h00);
        idle_cycles(5);
        checks += 2;
        if (rd_cnt != r0)       begin errors++; $display("FAIL burst_zero: got %0d reads, expected 0", rd_cnt - r0); end
        if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL burst_zero_busy: got %b, expected 0", CTRL_BUSY); end
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt;
        exp_rd.push_back(4'h3);
        exp_tx.push_back(exp_mem[3]);
        send_byte(8'hBB); send_byte(8'h03);
        // These land while busy and must vanish.
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11);
        wait_quiet(20);
        checks++;
        if (wr_cnt != w0) begin errors++; $display("FAIL busy_drop: got %0d writes, expected 0", wr_cnt - w0); end
        exp_rd.push_back(4'h4);
        exp_tx.push_back(exp_mem[4]);
        send_byte(8'hBB); send_byte(8'h04);
        wait_quiet(20);
    endtask

    task automatic test_bad_opcode();
        int w0 = wr_cnt;
        exp_wr.push_back({4'h1, 8'h7F});
        exp_mem[1] = 8'h7F;
        send_byte(8'h55);
        checks++;
        if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL bad_opcode_busy: got %b, expected 0", CTRL_BUSY); end
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7F);
        wait_quiet(10);
        // Operand bytes equal to opcodes are still operands; upper address bits ignored.
        exp_wr.push_back({4'hB, 8'hCC});
        exp_mem[11] = 8'hCC;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_quiet(10);
        checks++;
        if (wr_cnt - w0 != 2) begin errors++; $display("FAIL bad_opcode_writes: got %0d, expected 2", wr_cnt - w0); end
        exp_rd.push_back(4'hB);
        exp_tx.push_back(exp_mem[11]);
        send_byte(8'hBB); send_byte(8'hFB);
        wait_quiet(20);
    endtask

    task automatic test_reset_mid_read();
        int t0 = tx_cnt;
        send_byte(8'hBB); send_byte(8'h06);
        checks++;
        if (RdEn !== 1'b1) begin errors++; $display("FAIL midreset_RdEn: got %b, expected 1", RdEn); end
        RST = 1'b0;
        #1;
        checks++;
        if ({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CTRL_BUSY} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b/%b/%h/%h/%h/%b/%b, expected all 0",
                     WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CTRL_BUSY);
        end
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        idle_cycles(8);
        checks += 2;
        if (tx_cnt != t0)       begin errors++; $display("FAIL midreset_tx: got %0d pushes, expected 0", tx_cnt - t0); end
        if (CTRL_BUSY !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", CTRL_BUSY); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h7F + 8'(i);
        test_reset();
        test_write();
        test_read();
        test_fifo_full();
        test_burst();
        test_back_to_back();
        test_bad_opcode();
        test_reset_mid_read();
        checks++;
        if (exp_tx.size() + exp_rd.size() + exp_wr.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                     exp_tx.size() + exp_rd.size() + exp_wr.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
